// File: rtl/mem_port_arbiter.sv
// Arbitrates the single physical memory port between the I-cache (line reads)
// and the D-cache (line reads and write-backs). One line transfer is in flight
// at a time. Simultaneous requests are granted round-robin.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,

  // I-cache side (read-only line fills)
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,

  // D-cache side (line fills and write-backs)
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,

  // Physical memory side
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } state_t;

  state_t state;
  logic   op_write;      // latched operation of the granted transfer
  logic   last_grant_d;  // 1: the most recent grant went to the D-cache

  logic   i_req;
  logic   d_req;
  logic   grant_i;
  logic   grant_d;

  // A write-back wins over a read when the D-cache raises both strobes.
  assign i_req   = i_read;
  assign d_req   = d_read | d_write;

  // On a tie the requester that was not granted last time wins, so neither
  // side can starve the other.
  assign grant_d = d_req & (~i_req | ~last_grant_d);
  assign grant_i = i_req & ~grant_d;

  // Arbitration FSM: latch the granted request, drive the memory strobes,
  // capture read data and pulse the per-requester completion.
  // NOTE: every register in this block uses non-blocking assignment so all of
  // them update together at the edge from the values seen before it.
  // The wide data latches are reset too, because a defined zero is observable
  // on the cache-facing rdata ports right after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      op_write     <= 1'b0;
      last_grant_d <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state        <= BUSY_D;
            last_grant_d <= 1'b1;
            op_write     <= d_write;
            pmem_address <= d_address;
            pmem_wdata   <= d_wdata;
            pmem_read    <= ~d_write;
            pmem_write   <= d_write;
          end else if (grant_i) begin
            state        <= BUSY_I;
            last_grant_d <= 1'b0;
            op_write     <= 1'b0;
            pmem_address <= i_address;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
          end
        end

        BUSY_I: begin
          if (pmem_resp) begin
            state      <= RESP_I;
            i_rdata    <= pmem_rdata;
            i_resp     <= 1'b1;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end

        BUSY_D: begin
          if (pmem_resp) begin
            state <= RESP_D;
            if (!op_write) begin
              d_rdata <= pmem_rdata;
            end
            d_resp     <= 1'b1;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end

        RESP_I: begin
          state  <= IDLE;
          i_resp <= 1'b0;
        end

        RESP_D: begin
          state  <= IDLE;
          d_resp <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
          i_resp     <= 1'b0;
          d_resp     <= 1'b0;
        end
      endcase
    end
  end

endmodule
